// File: rtl/wb_register_file.sv
// Write-back stage and architectural register file: selects the write-back value, commits it,
// serves two bypassed combinational read ports and counts committed writes.
module wb_register_file #(
    parameter int unsigned WORD_LEN     = 32,
    parameter int unsigned REG_ADDR_LEN = 5,
    parameter int unsigned REG_COUNT    = 32
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    WB_EN_IN,
    input  logic                    MEM_READ_EN_IN,
    input  logic [WORD_LEN-1:0]     ALU_RESULT_IN,
    input  logic [WORD_LEN-1:0]     MEM_READ_OPERAND_IN,
    input  logic [REG_ADDR_LEN-1:0] DESTINATION_IN,
    input  logic [REG_ADDR_LEN-1:0] SRC1_ADDR,
    input  logic [REG_ADDR_LEN-1:0] SRC2_ADDR,
    output logic [WORD_LEN-1:0]     SRC1_DATA,
    output logic [WORD_LEN-1:0]     SRC2_DATA,
    output logic [WORD_LEN-1:0]     WB_VALUE_OUT,
    output logic [31:0]             WB_WRITE_COUNT
);

    // Register 0 is hardwired zero, so storage starts at index 1.
    logic [WORD_LEN-1:0] regs_q [1:REG_COUNT-1];
    logic [31:0]         write_count_q;
    logic [31:0]         write_count_d;
    logic                wr_eff;

    assign WB_VALUE_OUT   = MEM_READ_EN_IN ? MEM_READ_OPERAND_IN : ALU_RESULT_IN;
    assign wr_eff         = WB_EN_IN && !RESET && (DESTINATION_IN != '0);
    assign WB_WRITE_COUNT = write_count_q;

    always_comb begin
        write_count_d = write_count_q;
        if (wr_eff) begin
            write_count_d = write_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 1; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            write_count_q <= '0;
        end else begin
            if (wr_eff) begin
                regs_q[DESTINATION_IN] <= WB_VALUE_OUT;
            end
            write_count_q <= write_count_d;
        end
    end

    // Write-first bypass lets ID read a value being committed in the same cycle.
    always_comb begin
        SRC1_DATA = '0;
        if (RESET || SRC1_ADDR == '0) begin
            SRC1_DATA = '0;
        end else if (wr_eff && SRC1_ADDR == DESTINATION_IN) begin
            SRC1_DATA = WB_VALUE_OUT;
        end else begin
            SRC1_DATA = regs_q[SRC1_ADDR];
        end
    end

    always_comb begin
        SRC2_DATA = '0;
        if (RESET || SRC2_ADDR == '0) begin
            SRC2_DATA = '0;
        end else if (wr_eff && SRC2_ADDR == DESTINATION_IN) begin
            SRC2_DATA = WB_VALUE_OUT;
        end else begin
            SRC2_DATA = regs_q[SRC2_ADDR];
        end
    end

endmodule

// File: tb/tb_wb_register_file.sv
// Table-driven bench for wb_register_file: directed vectors with hand-computed results,
// plus a counter-wrap sequence.
module tb_wb_register_file;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic        mem_rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  dst;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] wbv;
    logic [31:0] cnt;

    int n_vec;
    int n_err;

    wb_register_file dut (
        .CLK                 (clk),
        .RESET               (rst),
        .WB_EN_IN            (wb_en),
        .MEM_READ_EN_IN      (mem_rd),
        .ALU_RESULT_IN       (alu),
        .MEM_READ_OPERAND_IN (mem),
        .DESTINATION_IN      (dst),
        .SRC1_ADDR           (a1),
        .SRC2_ADDR           (a2),
        .SRC1_DATA           (d1),
        .SRC2_DATA           (d2),
        .WB_VALUE_OUT        (wbv),
        .WB_WRITE_COUNT      (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  dst;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;   // read ports before the edge
        logic [31:0] e2;
        logic [31:0] ewb;
        logic [31:0] ecnt; // count after the edge
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    initial begin
        //            rst   we    mr    alu           mem           dst a1 a2 e1            e2            ewb           ecnt
        vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        0,  5, 0, 32'h0,        32'h0,        32'h0,        32'd0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 32'h1234,     32'h0,        5,  5, 7, 32'h1234,     32'h0,        32'h1234,     32'd1};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5,  5, 5, 32'h1234,     32'h1234,     32'h0,        32'd1};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h77,       32'h0,        0,  5, 5, 32'h0,        32'h0,        32'h77,       32'd0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        0,  5, 0, 32'h0,        32'h0,        32'h0,        32'd0};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 32'h11,       32'hDEADBEEF, 7,  7, 0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'd1};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 32'h22,       32'hDEADBEEF, 8,  7, 8, 32'hDEADBEEF, 32'h22,       32'h22,       32'd2};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 32'hAAAA,     32'h0,        3,  8, 3, 32'h22,       32'hAAAA,     32'hAAAA,     32'd3};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 32'h5555,     32'h0,        3,  3, 3, 32'h5555,     32'h5555,     32'h5555,     32'd4};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        3,  3, 7, 32'h5555,     32'hDEADBEEF, 32'h0,        32'd4};
        vt[10] = '{1'b0, 1'b1, 1'b0, 32'hFFFF,     32'h0,        0,  0, 3, 32'h0,        32'h5555,     32'hFFFF,     32'd4};
        vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        0,  0, 0, 32'h0,        32'h0,        32'h0,        32'd4};
        vt[12] = '{1'b0, 1'b0, 1'b0, 32'h1357,     32'h0,        9,  9, 9, 32'h0,        32'h0,        32'h1357,     32'd4};
        vt[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        0,  9, 8, 32'h0,        32'h22,       32'h0,        32'd4};
        vt[14] = '{1'b0, 1'b0, 1'b1, 32'h1,        32'hCAFE,     7,  7, 3, 32'hDEADBEEF, 32'h5555,     32'hCAFE,     32'd4};
        vt[15] = '{1'b0, 1'b1, 1'b0, 32'h22,       32'h0,        8,  8, 8, 32'h22,       32'h22,       32'h22,       32'd5};
        vt[16] = '{1'b1, 1'b1, 1'b0, 32'h99,       32'h0,        4,  4, 4, 32'h0,        32'h0,        32'h99,       32'd0};
        vt[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        0,  4, 7, 32'h0,        32'h0,        32'h0,        32'd0};

        n_vec = 0;
        n_err = 0;
        rst = 1'b1; wb_en = 1'b0; mem_rd = 1'b0; alu = '0; mem = '0; dst = '0; a1 = '0; a2 = '0;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            rst = vt[i].rst; wb_en = vt[i].we; mem_rd = vt[i].mr; alu = vt[i].alu;
            mem = vt[i].mem; dst = vt[i].dst; a1 = vt[i].a1; a2 = vt[i].a2;
            #1;
            check("src1", i, d1, vt[i].e1);
            check("src2", i, d2, vt[i].e2);
            check("wbval", i, wbv, vt[i].ewb);
            @(posedge clk);
            #1;
            check("count", i, cnt, vt[i].ecnt);
            @(negedge clk);
        end

        // Counter wrap: preload via the next-count node, then two real writes.
        rst = 1'b0; wb_en = 1'b1; mem_rd = 1'b0; alu = 32'h1; dst = 5'd10; a1 = 5'd10; a2 = 5'd0;
        force dut.write_count_d = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.write_count_d;
        #1;
        check("wrap_pre", 100, cnt, 32'hFFFF_FFFE);
        @(negedge clk);
        alu = 32'h2;
        @(posedge clk);
        #1;
        check("wrap_max", 101, cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        alu = 32'h3;
        @(posedge clk);
        #1;
        check("wrap_zero", 102, cnt, 32'h0000_0000);
        @(negedge clk);
        wb_en = 1'b0; alu = 32'h0;
        #1;
        check("r10_last", 103, d1, 32'h3);
        @(posedge clk);
        #1;
        check("hold_cnt", 104, cnt, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
